// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with wait timeout, sticky error flags and a retire counter.
// Strobes are decoded from the state register and mem_ready in the same cycle; FETCH/MEM stall until mem_ready.
module multicycle_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      cur;
    logic [7:0]  wait_cnt;
    logic [31:0] retired_q;
    logic        illegal_q;
    logic        bus_error_q;

    logic rdy;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_legal;
    logic waiting;
    logic timeout;

    // mem_ready is masked while reset is held so the reset-time outputs look like an idle FETCH
    assign rdy       = mem_ready & rst_n;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_legal  = opcode inside {OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
                                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign waiting   = (cur == FETCH) || (cur == MEM);
    assign timeout   = waiting && !rdy && (wait_cnt == 8'hFF);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_branch = 1'b0;
        reg_write = 1'b0;
        case (cur)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = rdy;
            end
            EXEC: begin
                if (is_branch) begin
                    pc_write  = 1'b1;
                    pc_branch = branch_taken;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                pc_write = rdy & is_store;
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= FETCH;
            wait_cnt    <= 8'd0;
            retired_q   <= 32'd0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            retired_q <= retired_q + {31'd0, pc_write};
            wait_cnt  <= (waiting && !rdy) ? wait_cnt + 8'd1 : 8'd0;
            case (cur)
                FETCH: begin
                    if (rdy) begin
                        cur <= DECODE;
                    end else if (timeout) begin
                        cur         <= HALT;
                        bus_error_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (is_legal) begin
                        cur <= EXEC;
                    end else begin
                        cur       <= HALT;
                        illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_load || is_store)
                        cur <= MEM;
                    else if (is_branch)
                        cur <= FETCH;
                    else
                        cur <= WB;
                end
                MEM: begin
                    if (rdy) begin
                        cur <= is_store ? FETCH : WB;
                    end else if (timeout) begin
                        cur         <= HALT;
                        bus_error_q <= 1'b1;
                    end
                end
                WB:   cur <= FETCH;
                HALT: cur <= HALT;
                default: begin
                    cur       <= HALT;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign state     = cur;
    assign halted    = (cur == HALT);
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: instruction-level reference model feeding a retire scoreboard, plus directed corner cases.
module tb_multicycle_seq;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_branch, reg_write;
    logic [2:0]  state;
    logic        halted, illegal, bus_error;
    logic [31:0] retired;

    multicycle_seq dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .reg_write(reg_write), .state(state),
        .halted(halted), .illegal(illegal), .bus_error(bus_error), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        pcb;
        logic        rw;
        logic        we;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [10:0] trace[$];
    logic [10:0] obs;
    logic [31:0] model_retired;
    int n_checks = 0, n_pass = 0;
    int lat_cnt = 0, ir_cnt = 0, exp_ir = 0, viol_we = 0, viol_rw = 0;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    assign obs = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_branch, reg_write, halted};

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Retire monitor: every pc_write pulse consumes one predicted instruction.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_cnt = 0;
        end else begin
            lat_cnt = lat_cnt + 1;
            if (mem_we && !mem_req) viol_we++;
            if (reg_write && !pc_write) viol_rw++;
            if (ir_write) ir_cnt++;
            if (pc_write) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_retire: pc_write with nothing pending, retired=%0d", retired);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("retire_latency", 64'(lat_cnt), 64'(mon_e.lat));
                    chk("retire_pc_branch", 64'(pc_branch), 64'(mon_e.pcb));
                    chk("retire_reg_write", 64'(reg_write), 64'(mon_e.rw));
                    chk("retire_mem_we", 64'(mem_we), 64'(mon_e.we));
                    chk("retire_count", 64'(retired), 64'(mon_e.ret));
                end
                lat_cnt = 0;
            end
        end
    end

    task automatic cyc(input logic rdy, input logic bt);
        mem_ready    = rdy;
        branch_taken = bt;
        @(negedge clk);
        trace.push_back(obs);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input int fw);
        repeat (fw) cyc(1'b0, rb());
        cyc(1'b1, rb());
        exp_ir++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = rb();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_retired = 32'd0;
        trace.delete();
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
        exp_t e;
        logic ldst, wb;
        ldst  = (op == OP_LOAD) || (op == OP_STORE);
        wb    = !((op == OP_STORE) || (op == OP_BRANCH));
        e.lat = fw + 3 + (ldst ? mw + 1 : 0) + (wb ? 1 : 0);
        e.pcb = (op == OP_BRANCH) && bt;
        e.rw  = wb;
        e.we  = (op == OP_STORE);
        e.ret = model_retired;
        exp_q.push_back(e);
        model_retired = model_retired + 32'd1;
        opcode = op;
        fetch_phase(fw);
        cyc(rb(), rb());
        cyc(rb(), bt);
        if (ldst) begin
            repeat (mw) cyc(1'b0, rb());
            cyc(1'b1, rb());
        end
        if (wb) cyc(rb(), rb());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] add_exp [5];
        logic [2:0]  ld_states [8];
        int bad;

        add_exp   = '{11'b000_1001_0000, 11'b001_0000_0000, 11'b010_0000_0000,
                      11'b100_0000_1010, 11'b000_1001_0000};
        ld_states = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};

        rst_n = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_BRANCH;
        model_retired = 32'd0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'(obs), 64'(11'b000_1000_0000));
        chk("reset_retired", 64'(retired), 64'd0);
        chk("reset_flags", 64'({illegal, bus_error}), 64'd0);

        // ALU instruction with memory always ready
        do_reset();
        run_instr(OP_ALU, 0, 0, 1'b0);
        chk("add_retired", 64'(retired), 64'd1);
        run_instr(OP_ALU, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) chk("add_sequence", 64'(trace[i]), 64'(add_exp[i]));

        // Load with three MEM wait cycles
        do_reset();
        run_instr(OP_LOAD, 0, 3, 1'b0);
        for (int i = 0; i < 8; i++) chk("load_states", 64'(trace[i][10:8]), 64'(ld_states[i]));
        for (int i = 3; i < 7; i++) chk("load_mem_ctl", 64'(trace[i][7:5]), 64'(3'b101));
        chk("load_retired", 64'(retired), 64'd1);

        // Branch taken, then not taken
        do_reset();
        run_instr(OP_BRANCH, 0, 0, 1'b1);
        run_instr(OP_ALU, 0, 0, 1'b0);
        run_instr(OP_BRANCH, 0, 0, 1'b0);
        chk("br_taken_exec", 64'(trace[2]), 64'(11'b010_0000_1100));
        chk("br_next_fetch", 64'(trace[3][10:8]), 64'd0);
        chk("br_not_taken_exec", 64'(trace[9]), 64'(11'b010_0000_1000));

        // Illegal opcode halts and stays quiet
        do_reset();
        run_instr(OP_ALU, 0, 0, 1'b0);
        trace.delete();
        opcode = 7'b1111111;
        fetch_phase(0);
        cyc(rb(), rb());
        repeat (100) cyc(rb(), rb());
        bad = 0;
        for (int i = 2; i < 102; i++) if (trace[i] !== 11'b101_0000_0001) bad++;
        chk("halt_quiet_cycles", 64'(bad), 64'd0);
        chk("illegal_flags", 64'({illegal, halted, bus_error}), 64'(3'b110));
        chk("illegal_retired", 64'(retired), 64'd1);

        // Fetch timeout on the 256th wait cycle
        do_reset();
        repeat (257) cyc(1'b0, rb());
        chk("fetch_wait_255", 64'(trace[255][10:8]), 64'd0);
        chk("fetch_timeout_halt", 64'(trace[256]), 64'(11'b101_0000_0001));
        chk("fetch_timeout_flags", 64'({bus_error, illegal, halted}), 64'(3'b101));

        // Ready arriving on the 256th wait cycle wins; MEM edge too
        do_reset();
        run_instr(OP_ALU, 255, 0, 1'b0);
        run_instr(OP_STORE, 0, 255, 1'b0);
        chk("wait_edge_flags", 64'({bus_error, halted}), 64'd0);
        chk("wait_edge_retired", 64'(retired), 64'd2);

        // MEM timeout during a store
        do_reset();
        opcode = OP_STORE;
        fetch_phase(0);
        cyc(rb(), rb());
        cyc(rb(), rb());
        repeat (257) cyc(1'b0, rb());
        chk("store_mem_ctl", 64'(trace[3][7:5]), 64'(3'b111));
        chk("mem_timeout_halt", 64'(trace[259][10:8]), 64'd5);
        chk("mem_timeout_flag", 64'(bus_error), 64'd1);

        // Asynchronous reset in the middle of a MEM wait
        do_reset();
        run_instr(OP_ALU, 0, 0, 1'b0);
        run_instr(OP_ALU, 0, 0, 1'b0);
        opcode = OP_LOAD;
        fetch_phase(0);
        cyc(rb(), rb());
        cyc(rb(), rb());
        repeat (5) cyc(1'b0, rb());
        chk("midmem_before", 64'(trace[trace.size() - 1][10:8]), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midmem_state", 64'({state, mem_req, mem_we, addr_sel}), 64'({3'd0, 3'b100}));
        chk("midmem_retired", 64'(retired), 64'd0);
        chk("midmem_flags", 64'({illegal, bus_error, halted}), 64'd0);

        // Retire counter wrap
        do_reset();
        model_retired = 32'hFFFF_FFFF;
        fork
            run_instr(OP_ALU, 0, 0, 1'b0);
            begin
                #3;
                force dut.retired_q = 32'hFFFF_FFFF;
                #10;
                release dut.retired_q;
            end
        join
        chk("retired_wrap", 64'(retired), 64'd0);

        // Randomized instruction stream
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int fw, mw;
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 2));
            run_instr(legal_ops[$urandom_range(0, 8)], fw, mw, rb());
        end
        chk("random_retired", 64'(retired), 64'd60);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("ir_write_pulses", 64'(ir_cnt), 64'(exp_ir));
        chk("we_without_req", 64'(viol_we), 64'd0);
        chk("reg_write_alone", 64'(viol_rw), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
